majority_voter: RTL and testbench

MAJORITY_VOTER -- requirements
Module: majority_voter

---
 rtl/majority_pkg.sv | 17 +
 rtl/majority_bit.sv | 25 ++
 rtl/majority_voter.sv | 120 ++++++++++++
 tb/tb_majority_voter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared limits, default parameter values and the fault-counter width helper
// used by the majority voter and its tests.
package majority_pkg;

    localparam int N_MAX        = 15;
    localparam int FAULT_TH_MAX = 255;

    localparam int N_DEF        = 3;
    localparam int W_DEF        = 1;
    localparam int FAULT_TH_DEF = 3;

    // Bits needed to count from 0 up to and including th.
    function automatic int cnt_width(input int th);
        return $clog2(th + 1);
    endfunction

endpackage

// File: rtl/majority_bit.sv
// Combinational N-input majority for one bit position: popcount compared
// against the strict-majority threshold (N is odd, so no ties).
module majority_bit
    import majority_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] bits_i,
    output logic         vote_o
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF = CW'((N + 1) / 2);

    logic [CW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + CW'(bits_i[i]);
        end
        vote_o = (ones >= HALF);
    end

endmodule

// File: rtl/majority_voter.sv
// N-channel, W-bit majority voter with one-cycle latency, per-channel
// disagreement flags and sticky faults after FAULT_TH consecutive disagreements.
module majority_voter
    import majority_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int W        = W_DEF,
    parameter int FAULT_TH = FAULT_TH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic           flt_clr,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   disagree,
    output logic [N-1:0]   fault,
    output logic           any_fault
);

    localparam int CW = cnt_width(FAULT_TH);
    localparam logic [CW-1:0] TH  = CW'(FAULT_TH);
    localparam logic [CW-1:0] ONE = CW'(1);

    if ((N % 2) == 0 || N < 3 || N > N_MAX) begin : g_bad_n
        $error("majority_voter: N=%0d must be odd and in 3..%0d", N, N_MAX);
    end
    if (W < 1) begin : g_bad_w
        $error("majority_voter: W=%0d must be >= 1", W);
    end
    if (FAULT_TH < 1 || FAULT_TH > FAULT_TH_MAX) begin : g_bad_th
        $error("majority_voter: FAULT_TH=%0d must be in 1..%0d", FAULT_TH, FAULT_TH_MAX);
    end

    logic [W-1:0] vote;
    logic [N-1:0] dis;

    // Transpose so each voter sees bit j of every channel.
    for (genvar j = 0; j < W; j++) begin : g_bit
        logic [N-1:0] col;
        for (genvar i = 0; i < N; i++) begin : g_ch
            assign col[i] = in_data[i*W + j];
        end
        majority_bit #(.N(N)) u_bit (
            .bits_i (col),
            .vote_o (vote[j])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dis[i] = (in_data[i*W +: W] != vote);
        end
    end

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [N-1:0]  disagree_q;
    logic [N-1:0]  fault_q, fault_d;
    logic          any_fault_q;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // Faulted channels still vote; the flag is observational only.
    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (flt_clr) begin
            fault_d = '0;
            for (int i = 0; i < N; i++) begin
                cnt_d[i] = '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < N; i++) begin
                if (dis[i]) begin
                    cnt_d[i] = (cnt_q[i] == TH) ? cnt_q[i] : cnt_q[i] + ONE;
                end else begin
                    cnt_d[i] = '0;
                end
                if (cnt_d[i] == TH) begin
                    fault_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            disagree_q  <= '0;
            fault_q     <= '0;
            any_fault_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q <= vote;
                disagree_q <= dis;
            end
            fault_q     <= fault_d;
            any_fault_q <= |fault_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign disagree  = disagree_q;
    assign fault     = fault_q;
    assign any_fault = any_fault_q;

endmodule

// File: tb/tb_majority_voter.sv
// Directed bench: a 3x4-bit voter (FAULT_TH=3) and a 5x1-bit voter, hand-computed expectations.
module tb_majority_voter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 3 channels x 4 bits
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        flt_clr;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [2:0]  disagree;
    logic [2:0]  fault;
    logic        any_fault;

    // 5 channels x 1 bit
    logic        rst_n5;
    logic        in_valid5;
    logic [4:0]  in_data5;
    logic        flt_clr5;
    logic        out_valid5;
    logic [0:0]  out_data5;
    logic [4:0]  disagree5;
    logic [4:0]  fault5;
    logic        any_fault5;

    majority_voter #(.N(3), .W(4), .FAULT_TH(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flt_clr   (flt_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .disagree  (disagree),
        .fault     (fault),
        .any_fault (any_fault)
    );

    majority_voter #(.N(5), .W(1), .FAULT_TH(3)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n5),
        .in_valid  (in_valid5),
        .in_data   (in_data5),
        .flt_clr   (flt_clr5),
        .out_valid (out_valid5),
        .out_data  (out_data5),
        .disagree  (disagree5),
        .fault     (fault5),
        .any_fault (any_fault5)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of input just after an edge, then sample #1 after the next edge.
    task automatic send(input logic v, input logic [11:0] d, input logic clr);
        in_valid = v;
        in_data  = d;
        flt_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flt_clr  = 1'b0;
    endtask

    task automatic send5(input logic v, input logic [4:0] d);
        in_valid5 = v;
        in_data5  = d;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
    endtask

    // Packing {ch2, ch1, ch0}
    localparam logic [11:0] AGREE = 12'hAAA;  // all channels 1010
    localparam logic [11:0] DIS2  = 12'h5AA;  // ch2 = 0101, others 1010

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flt_clr = 1'b0;
        rst_n5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0; flt_clr5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_dis", 32'(disagree), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_any", 32'(any_fault), 32'h0);
        #3;
        rst_n = 1'b1;
        rst_n5 = 1'b1;
        @(posedge clk);
        #1;

        // basic vote, ch2 outvoted
        send(1'b1, DIS2, 1'b0);
        chk("v1_valid", 32'(out_valid), 32'h1);
        chk("v1_data", 32'(out_data), 32'hA);
        chk("v1_dis", 32'(disagree), 32'h4);
        chk("v1_fault", 32'(fault), 32'h0);

        // invalid cycle: valid drops, data/disagree hold
        send(1'b0, 12'h000, 1'b0);
        chk("gap_valid", 32'(out_valid), 32'h0);
        chk("gap_data", 32'(out_data), 32'hA);
        chk("gap_dis", 32'(disagree), 32'h4);

        send(1'b1, AGREE, 1'b0);
        chk("agree_dis", 32'(disagree), 32'h0);

        // ch0=1100 ch1=1010 ch2=0110 -> 1110, all three disagree
        send(1'b1, 12'h6AC, 1'b0);
        chk("mix_data", 32'(out_data), 32'hE);
        chk("mix_dis", 32'(disagree), 32'h7);
        send(1'b1, AGREE, 1'b0);

        // three consecutive disagreements -> fault, fourth saturates
        send(1'b1, DIS2, 1'b0);
        chk("f1_fault", 32'(fault), 32'h0);
        send(1'b1, DIS2, 1'b0);
        chk("f2_fault", 32'(fault), 32'h0);
        chk("f2_any", 32'(any_fault), 32'h0);
        send(1'b1, DIS2, 1'b0);
        chk("f3_fault", 32'(fault), 32'h4);
        chk("f3_any", 32'(any_fault), 32'h1);
        send(1'b1, DIS2, 1'b0);
        chk("f4_fault", 32'(fault), 32'h4);
        send(1'b1, AGREE, 1'b0);
        chk("sticky_fault", 32'(fault), 32'h4);
        send(1'b0, AGREE, 1'b1);
        chk("clr_fault", 32'(fault), 32'h0);
        chk("clr_any", 32'(any_fault), 32'h0);

        // an agreeing sample breaks the run
        send(1'b1, DIS2, 1'b0);
        send(1'b1, DIS2, 1'b0);
        send(1'b1, AGREE, 1'b0);
        send(1'b1, DIS2, 1'b0);
        send(1'b1, DIS2, 1'b0);
        chk("brk_fault", 32'(fault), 32'h0);
        send(1'b1, AGREE, 1'b0);

        // gaps of two invalid cycles do not break the run
        send(1'b1, DIS2, 1'b0);
        send(1'b0, DIS2, 1'b0);
        chk("g1_valid", 32'(out_valid), 32'h0);
        send(1'b0, AGREE, 1'b0);
        chk("g2_valid", 32'(out_valid), 32'h0);
        send(1'b1, DIS2, 1'b0);
        chk("g3_fault", 32'(fault), 32'h0);
        send(1'b0, DIS2, 1'b0);
        send(1'b0, DIS2, 1'b0);
        chk("g4_valid", 32'(out_valid), 32'h0);
        send(1'b1, DIS2, 1'b0);
        chk("g5_valid", 32'(out_valid), 32'h1);
        chk("g5_fault", 32'(fault), 32'h4);
        send(1'b0, AGREE, 1'b1);
        chk("g_clr", 32'(fault), 32'h0);

        // clear coinciding with the third disagreement wins
        send(1'b1, DIS2, 1'b0);
        send(1'b1, DIS2, 1'b0);
        send(1'b1, 12'hC33, 1'b1);  // ch0=ch1=0011, ch2=1100
        chk("cc_valid", 32'(out_valid), 32'h1);
        chk("cc_data", 32'(out_data), 32'h3);
        chk("cc_dis", 32'(disagree), 32'h4);
        chk("cc_fault", 32'(fault), 32'h0);
        chk("cc_any", 32'(any_fault), 32'h0);
        send(1'b1, DIS2, 1'b0);
        chk("cc_next_fault", 32'(fault), 32'h0);

        // N=5, W=1
        send5(1'b1, 5'b11100);
        chk("n5_data", 32'(out_data5), 32'h1);
        chk("n5_dis", 32'(disagree5), 32'h03);
        send5(1'b1, 5'b00011);
        chk("n5_data0", 32'(out_data5), 32'h0);
        chk("n5_dis0", 32'(disagree5), 32'h03);
        // ch0/ch1 counters now at 2; async reset mid-run
        rst_n5 = 1'b0;
        #1;
        chk("n5_rst_valid", 32'(out_valid5), 32'h0);
        chk("n5_rst_data", 32'(out_data5), 32'h0);
        chk("n5_rst_dis", 32'(disagree5), 32'h0);
        chk("n5_rst_fault", 32'(fault5), 32'h0);
        #2;
        rst_n5 = 1'b1;
        @(posedge clk);
        #1;
        send5(1'b1, 5'b11100);
        chk("n5_r1_fault", 32'(fault5), 32'h0);
        send5(1'b1, 5'b11100);
        chk("n5_r2_fault", 32'(fault5), 32'h0);
        send5(1'b1, 5'b11100);
        chk("n5_r3_fault", 32'(fault5), 32'h03);
        chk("n5_r3_any", 32'(any_fault5), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
